multicycle_cpu_controller: RTL and testbench
============================================

# multicycle_cpu_controller

Multi-cycle control unit for the MIPS CPU. It replaces the single-cycle combinational decoder with a state machine that sequences fetch, decode, execute, memory and writeback. Memory and memory-mapped I/O accesses use a ready handshake so they can take wait states. The I/O decode is parametrised to an arbitrary device count. The block sits between the instruction register / ALU address path and the datapath muxes, register file, data memory and I/O bus.

## Interface
Parameters:
- IO_DEVICE_COUNT, 16: number of one-hot I/O select lines; must be 1..2^IO_INDEX_WIDTH.
- IO_INDEX_LSB, 4: lowest address bit of the I/O device index.
- IO_INDEX_WIDTH, 4: width of the I/O device index field.
- TIMEOUT_CYCLES, 255: bus wait limit; used only with the timeout feature.

Ports (one clock; reset is asynchronous and active-high):
- iClock  in  1  system clock; all state changes on the rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iOperationCode  in  6  instruction[31:26] from the instruction register.
- iFunctionCode  in  6  instruction[5:0].
- iAluAddress  in  32  ALU result, used as the effective address in the MEM state.
- iInstrReady  in  1  instruction memory has data valid.
- iBusReady  in  1  data memory or I/O access is complete.
- oInstrRequest  out  1  instruction fetch request.
- oIrWrite  out  1  load the instruction register.
- oPcWrite  out  1  update the PC.
- oPcSource  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = register (jr).
- oBranchEvaluate  out  1  commit the branch if the condition holds (beq uses zero, bne uses !zero).
- oIsBne  out  1  selects the bne condition.
- oAluOp  out  2  10 = R-type / arithmetic I-type, 01 = branch, 00 = address calculation.
- oIsAluSource2FromImm  out  1  ALU operand 2 comes from the immediate.
- oIsShift  out  1  shift instruction.
- oRegDst  out  2  00 = rt, 01 = rd, 10 = $31.
- oRegSource  out  2  00 = ALU, 01 = memory/IO, 10 = PC+4 (jal).
- oDoWriteReg  out  1  register-file write strobe.
- oDoMemoryRead  out  1  data memory read.
- oDoMemoryWrite  out  1  data memory write.
- oIoRead  out  1  I/O read strobe.
- oIoWrite  out  1  I/O write strobe.
- oIoSelect  out  IO_DEVICE_COUNT  one-hot I/O device select.
- oIllegalInstr  out  1  one-cycle pulse on an unsupported opcode.
- oBusError  out  1  one-cycle pulse on bus timeout (timeout build only).

## Operation
States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, JUMP.
- **FETCH**
  - Assert oInstrRequest.
  - On iInstrReady: assert oIrWrite and oPcWrite with oPcSource=00, then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE**
  - Latch opcode and funct into internal registers; all later states use only these latched copies.
  - j or jal goes to JUMP.
  - An opcode outside {R, j, jal, beq, bne, 001xxx, lw, sw} pulses oIllegalInstr and goes to FETCH.
  - Everything else goes to EXECUTE.
- **EXECUTE**
  - Drive oAluOp, oIsAluSource2FromImm and oIsShift. oIsShift covers R-type funct 000000, 000010, 000011, 000100, 000110, 000111.
  - beq/bne: oBranchEvaluate=1, oPcSource=01, oIsBne as decoded, then FETCH.
  - jr (R-type, funct 001000): oPcWrite=1, oPcSource=11, then FETCH.
  - lw/sw go to MEM.
  - Other R-type and arithmetic I-type instructions go to WRITEBACK.
- **MEM**
  - iAluAddress[31:10]==22'h3FFFFF selects I/O; any other address selects memory.
  - Memory access: assert oDoMemoryRead (lw) or oDoMemoryWrite (sw).
  - I/O access: assert oIoRead or oIoWrite. oIoSelect has bit idx=iAluAddress[IO_INDEX_LSB+:IO_INDEX_WIDTH] set.
  - If idx >= IO_DEVICE_COUNT, oIoSelect=0 and the access still completes on iBusReady.
  - The address decode is registered on MEM entry and held stable for the whole MEM residency.
  - On iBusReady: lw goes to WRITEBACK, sw goes to FETCH.
- **WRITEBACK**
  - Single cycle with oDoWriteReg=1.
  - lw: oRegSource=01, oRegDst=00.
  - R-type: oRegSource=00, oRegDst=01.
  - I-type: oRegSource=00, oRegDst=00.
  - Then FETCH.
- **JUMP**
  - oPcWrite=1, oPcSource=10.
  - jal additionally sets oDoWriteReg=1, oRegDst=10, oRegSource=10.
  - Then FETCH.
- A register write to $0 is not blocked here; the register file owns that rule.
- Only one of oDoMemoryRead, oDoMemoryWrite, oIoRead, oIoWrite is ever asserted at a time.

## Timing
- Outputs are Moore-style: decoded from the state register and the latched opcode, funct and address.
- Reset: state=FETCH. Every output is 0 while iReset is high.
- The first cycle after reset release asserts oInstrRequest.
- Cycle counts with zero wait states: R/I-type 4, lw 5, sw 4, beq/bne/jr 3, j/jal 3.
- Each wait cycle on iInstrReady or iBusReady adds one cycle.
- Ready already high on the first cycle of FETCH or MEM means no stall.
- Reset asserted mid-operation (any state, including MEM with a strobe active) drops all strobes immediately, asynchronously. No partial write strobe survives into the next cycle.
- iBusReady arriving outside MEM is ignored.

## Configuration
- Macro CPU_CONTROLLER_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum wait counter runs in FETCH and MEM and clears on state entry.
  - After TIMEOUT_CYCLES consecutive cycles without ready, pulse oBusError for one cycle and go to FETCH.
  - A timeout in FETCH retries from the same PC, because no PC write occurs.
- Not defined: no counter; FETCH and MEM wait indefinitely; oBusError is tied to 0.

## Test plan
- Reset, then add (op 000000, funct 100000) with ready always high: states F,D,E,W over 4 cycles; oDoWriteReg=1 in cycle 4 only, with oRegDst=01.
- lw to address 0x00000040 with iBusReady low for 2 MEM cycles: oDoMemoryRead high for 3 cycles; WRITEBACK with oRegSource=01; total 7 cycles.
- sw to 0xFFFFFC20: oIoWrite=1, oIoSelect=16'h0004, oDoMemoryWrite=0; return to FETCH after iBusReady.
- sw to 0xFFFFFCF0 with IO_DEVICE_COUNT=4: oIoSelect=0 and oIoWrite=1; completes on ready.
- jal then jr: JUMP shows oRegDst=10, oRegSource=10, oPcSource=10; jr EXECUTE shows oPcSource=11 and no oDoWriteReg.
- iReset pulsed during MEM of sw: oIoWrite falls asynchronously; the first cycle after release is FETCH. With the macro, TIMEOUT_CYCLES=8 and iBusReady stuck low: oBusError pulses after 8 MEM cycles, then FETCH.

Source files
------------

// File: rtl/multicycle_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_cpu_controller
// Brief    : Multi-cycle MIPS control FSM (fetch/decode/execute/mem/writeback/jump)
//            with ready-handshaked memory and one-hot memory-mapped I/O select.
//            Optional bus timeout: define CPU_CONTROLLER_BUS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_cpu_controller #(
  parameter int IO_DEVICE_COUNT = 16,
  parameter int IO_INDEX_LSB    = 4,
  parameter int IO_INDEX_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic [5:0]                 iOperationCode,
  input  logic [5:0]                 iFunctionCode,
  input  logic [31:0]                iAluAddress,
  input  logic                       iInstrReady,
  input  logic                       iBusReady,
  output logic                       oInstrRequest,
  output logic                       oIrWrite,
  output logic                       oPcWrite,
  output logic [1:0]                 oPcSource,
  output logic                       oBranchEvaluate,
  output logic                       oIsBne,
  output logic [1:0]                 oAluOp,
  output logic                       oIsAluSource2FromImm,
  output logic                       oIsShift,
  output logic [1:0]                 oRegDst,
  output logic [1:0]                 oRegSource,
  output logic                       oDoWriteReg,
  output logic                       oDoMemoryRead,
  output logic                       oDoMemoryWrite,
  output logic                       oIoRead,
  output logic                       oIoWrite,
  output logic [IO_DEVICE_COUNT-1:0] oIoSelect,
  output logic                       oIllegalInstr,
  output logic                       oBusError
);

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] EXECUTE   = 3'd2;
  localparam logic [2:0] MEM       = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  localparam logic [2:0] JUMP      = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [2:0]                rState, wNextState;
  logic [5:0]                rOpcode, rFunct;
  logic                      rIsIo;
  logic [IO_INDEX_WIDTH-1:0] rIoIndex;
  logic                      wTimeout;

  logic wIsRType, wIsArithI, wIsLoad, wIsStore, wIsBranch, wIsJr, wIsJal, wIsShift;
  logic wNewIsJump, wNewIsLegal, wAddrIsIo, wIoActive, wUnusedAddressBits;
  logic [IO_INDEX_WIDTH-1:0] wAddrIndex;

  assign wIsRType  = (rOpcode == OP_RTYPE);
  assign wIsArithI = (rOpcode[5:3] == 3'b001);
  assign wIsLoad   = (rOpcode == OP_LW);
  assign wIsStore  = (rOpcode == OP_SW);
  assign wIsBranch = (rOpcode == OP_BEQ) || (rOpcode == OP_BNE);
  assign wIsJal    = (rOpcode == OP_JAL);
  assign wIsJr     = wIsRType && (rFunct == FN_JR);
  assign wIsShift  = wIsRType && (rFunct inside {6'b000000, 6'b000010, 6'b000011,
                                                 6'b000100, 6'b000110, 6'b000111});

  // DECODE is the only state that looks at the live instruction register.
  assign wNewIsJump  = (iOperationCode == OP_J) || (iOperationCode == OP_JAL);
  assign wNewIsLegal = (iOperationCode == OP_RTYPE) || wNewIsJump ||
                       (iOperationCode == OP_BEQ) || (iOperationCode == OP_BNE) ||
                       (iOperationCode[5:3] == 3'b001) ||
                       (iOperationCode == OP_LW) || (iOperationCode == OP_SW);

  assign wAddrIsIo          = &iAluAddress[31:10];
  assign wAddrIndex         = iAluAddress[IO_INDEX_LSB +: IO_INDEX_WIDTH];
  assign wUnusedAddressBits = ^iAluAddress[9:0];

  always_comb begin
    wNextState = rState;
    case (rState)
      FETCH: begin
        if (iInstrReady)   wNextState = DECODE;
        else if (wTimeout) wNextState = FETCH;
      end
      DECODE: begin
        if (wNewIsJump)        wNextState = JUMP;
        else if (!wNewIsLegal) wNextState = FETCH;
        else                   wNextState = EXECUTE;
      end
      EXECUTE: begin
        if (wIsBranch || wIsJr)     wNextState = FETCH;
        else if (wIsLoad || wIsStore) wNextState = MEM;
        else                        wNextState = WRITEBACK;
      end
      MEM: begin
        if (iBusReady)     wNextState = wIsLoad ? WRITEBACK : FETCH;
        else if (wTimeout) wNextState = FETCH;
      end
      default: wNextState = FETCH;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      rState   <= FETCH;
      rOpcode  <= '0;
      rFunct   <= '0;
      rIsIo    <= 1'b0;
      rIoIndex <= '0;
    end else begin
      rState <= wNextState;
      if (rState == DECODE) begin
        rOpcode <= iOperationCode;
        rFunct  <= iFunctionCode;
      end
      // Address decode captured on MEM entry so selects stay glitch-free while waiting.
      if (rState == EXECUTE) begin
        rIsIo    <= wAddrIsIo;
        rIoIndex <= wAddrIndex;
      end
    end
  end

`ifdef CPU_CONTROLLER_BUS_TIMEOUT_EN
  localparam int WAIT_WIDTH = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WAIT_WIDTH-1:0] rWaitCount;
  logic                  wWaiting;

  assign wWaiting = ((rState == FETCH) && !iInstrReady) || ((rState == MEM) && !iBusReady);
  assign wTimeout = wWaiting && (rWaitCount == WAIT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign oBusError = wTimeout && !iReset;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset)                                         rWaitCount <= '0;
    else if (!wWaiting || wTimeout || (wNextState != rState)) rWaitCount <= '0;
    else                                                rWaitCount <= rWaitCount + 1'b1;
  end
`else
  // No wait limit: the parameter only remains for interface compatibility.
  assign wTimeout  = 1'b0 & (TIMEOUT_CYCLES == 0);
  assign oBusError = 1'b0;
`endif

  assign wIoActive = !iReset && (rState == MEM) && rIsIo;

  for (genvar i = 0; i < IO_DEVICE_COUNT; i++) begin : g_ioSelect
    assign oIoSelect[i] = wIoActive && (rIoIndex == IO_INDEX_WIDTH'(i));
  end

  always_comb begin
    oInstrRequest        = 1'b0;
    oIrWrite             = 1'b0;
    oPcWrite             = 1'b0;
    oPcSource            = 2'b00;
    oBranchEvaluate      = 1'b0;
    oIsBne               = 1'b0;
    oAluOp               = 2'b00;
    oIsAluSource2FromImm = 1'b0;
    oIsShift             = 1'b0;
    oRegDst              = 2'b00;
    oRegSource           = 2'b00;
    oDoWriteReg          = 1'b0;
    oDoMemoryRead        = 1'b0;
    oDoMemoryWrite       = 1'b0;
    oIoRead              = 1'b0;
    oIoWrite             = 1'b0;
    oIllegalInstr        = 1'b0;
    if (!iReset) begin
      case (rState)
        FETCH: begin
          oInstrRequest = 1'b1;
          oIrWrite      = iInstrReady;
          oPcWrite      = iInstrReady;
        end
        DECODE: oIllegalInstr = !wNewIsLegal;
        EXECUTE: begin
          oAluOp               = wIsBranch ? 2'b01 : ((wIsLoad || wIsStore) ? 2'b00 : 2'b10);
          oIsAluSource2FromImm = wIsArithI || wIsLoad || wIsStore;
          oIsShift             = wIsShift;
          if (wIsBranch) begin
            oBranchEvaluate = 1'b1;
            oPcSource       = 2'b01;
            oIsBne          = (rOpcode == OP_BNE);
          end
          if (wIsJr) begin
            oPcWrite  = 1'b1;
            oPcSource = 2'b11;
          end
        end
        MEM: begin
          oDoMemoryRead  = !rIsIo && wIsLoad;
          oDoMemoryWrite = !rIsIo && wIsStore;
          oIoRead        = rIsIo && wIsLoad;
          oIoWrite       = rIsIo && wIsStore;
        end
        WRITEBACK: begin
          oDoWriteReg = 1'b1;
          if (wIsLoad)       oRegSource = 2'b01;
          else if (wIsRType) oRegDst    = 2'b01;
        end
        JUMP: begin
          oPcWrite  = 1'b1;
          oPcSource = 2'b10;
          if (wIsJal) begin
            oDoWriteReg = 1'b1;
            oRegDst     = 2'b10;
            oRegSource  = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_cpu_controller
// Brief    : Scoreboard bench: per-cycle expected control words queued with stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_cpu_controller;

  logic        iClock = 1'b0, iReset = 1'b1;
  logic [5:0]  iOperationCode = '0, iFunctionCode = '0;
  logic [31:0] iAluAddress = '0;
  logic        iInstrReady = 1'b0, iBusReady = 1'b0;

  logic        oInstrRequest, oIrWrite, oPcWrite, oBranchEvaluate, oIsBne;
  logic [1:0]  oPcSource, oAluOp, oRegDst, oRegSource;
  logic        oIsAluSource2FromImm, oIsShift, oDoWriteReg, oDoMemoryRead, oDoMemoryWrite;
  logic        oIoRead, oIoWrite, oIllegalInstr, oBusError;
  logic [15:0] oIoSelect;

  logic        oInstrRequest2, oIrWrite2, oPcWrite2, oBranchEvaluate2, oIsBne2;
  logic [1:0]  oPcSource2, oAluOp2, oRegDst2, oRegSource2;
  logic        oIsAluSource2FromImm2, oIsShift2, oDoWriteReg2, oDoMemoryRead2, oDoMemoryWrite2;
  logic        oIoRead2, oIoWrite2, oIllegalInstr2, oBusError2;
  logic [3:0]  oIoSelect2;

  always #5 iClock = ~iClock;

  multicycle_cpu_controller #(.TIMEOUT_CYCLES(8)) dut (
    .iClock(iClock), .iReset(iReset), .iOperationCode(iOperationCode),
    .iFunctionCode(iFunctionCode), .iAluAddress(iAluAddress),
    .iInstrReady(iInstrReady), .iBusReady(iBusReady),
    .oInstrRequest(oInstrRequest), .oIrWrite(oIrWrite), .oPcWrite(oPcWrite),
    .oPcSource(oPcSource), .oBranchEvaluate(oBranchEvaluate), .oIsBne(oIsBne),
    .oAluOp(oAluOp), .oIsAluSource2FromImm(oIsAluSource2FromImm), .oIsShift(oIsShift),
    .oRegDst(oRegDst), .oRegSource(oRegSource), .oDoWriteReg(oDoWriteReg),
    .oDoMemoryRead(oDoMemoryRead), .oDoMemoryWrite(oDoMemoryWrite),
    .oIoRead(oIoRead), .oIoWrite(oIoWrite), .oIoSelect(oIoSelect),
    .oIllegalInstr(oIllegalInstr), .oBusError(oBusError));

  multicycle_cpu_controller #(.IO_DEVICE_COUNT(4), .TIMEOUT_CYCLES(8)) dut4 (
    .iClock(iClock), .iReset(iReset), .iOperationCode(iOperationCode),
    .iFunctionCode(iFunctionCode), .iAluAddress(iAluAddress),
    .iInstrReady(iInstrReady), .iBusReady(iBusReady),
    .oInstrRequest(oInstrRequest2), .oIrWrite(oIrWrite2), .oPcWrite(oPcWrite2),
    .oPcSource(oPcSource2), .oBranchEvaluate(oBranchEvaluate2), .oIsBne(oIsBne2),
    .oAluOp(oAluOp2), .oIsAluSource2FromImm(oIsAluSource2FromImm2), .oIsShift(oIsShift2),
    .oRegDst(oRegDst2), .oRegSource(oRegSource2), .oDoWriteReg(oDoWriteReg2),
    .oDoMemoryRead(oDoMemoryRead2), .oDoMemoryWrite(oDoMemoryWrite2),
    .oIoRead(oIoRead2), .oIoWrite(oIoWrite2), .oIoSelect(oIoSelect2),
    .oIllegalInstr(oIllegalInstr2), .oBusError(oBusError2));

  typedef struct packed {
    logic instrReq, irWrite, pcWrite;
    logic [1:0] pcSource;
    logic branchEval, isBne;
    logic [1:0] aluOp;
    logic imm, shift;
    logic [1:0] regDst, regSource;
    logic doWriteReg, memRead, memWrite, ioRead, ioWrite, illegal, busError;
    logic [15:0] ioSelect;
  } ctl_t;

  typedef struct packed {
    logic instrReady;
    logic busReady;
    ctl_t exp;
  } step_t;

  step_t sb[$];
  ctl_t  obs;
  int    errors = 0, checks = 0;

  assign obs = {oInstrRequest, oIrWrite, oPcWrite, oPcSource, oBranchEvaluate, oIsBne,
                oAluOp, oIsAluSource2FromImm, oIsShift, oRegDst, oRegSource, oDoWriteReg,
                oDoMemoryRead, oDoMemoryWrite, oIoRead, oIoWrite, oIllegalInstr, oBusError,
                oIoSelect};

  function automatic ctl_t fetchExp(input logic rdy);
    ctl_t e = '0;
    e.instrReq = 1'b1; e.irWrite = rdy; e.pcWrite = rdy;
    return e;
  endfunction

  function automatic ctl_t execExp(input logic [1:0] aluOp, input logic imm, input logic shift);
    ctl_t e = '0;
    e.aluOp = aluOp; e.imm = imm; e.shift = shift;
    return e;
  endfunction

  task automatic push(input logic ir, input logic br, input ctl_t e);
    step_t s;
    s.instrReady = ir; s.busReady = br; s.exp = e;
    sb.push_back(s);
  endtask

  task automatic test_reset();
    iReset = 1'b1; iInstrReady = 1'b1; iBusReady = 1'b1;
    repeat (2) @(posedge iClock);
    @(negedge iClock);
    checks++;
    if (obs !== ctl_t'(0)) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs, ctl_t'(0));
    end
    @(posedge iClock); #1;
    iReset = 1'b0; iInstrReady = 1'b0; iBusReady = 1'b0;
    @(negedge iClock);
    checks++;
    if (obs !== fetchExp(1'b0)) begin
      errors++; $display("FAIL reset_first_fetch: got %h expected %h", obs, fetchExp(1'b0));
    end
    @(posedge iClock); #1;
  endtask

  task automatic test_alu_ops();
    ctl_t e;
    logic [5:0] ops [3] = '{6'b000000, 6'b000000, 6'b001000};
    logic [5:0] fns [3] = '{6'b100000, 6'b000000, 6'b000000};
    for (int k = 0; k < 3; k++) begin
      iOperationCode = ops[k]; iFunctionCode = fns[k];
      push(1'b1, 1'b0, fetchExp(1'b1));
      push(1'b0, 1'b0, ctl_t'(0));
      push(1'b0, 1'b0, execExp(2'b10, k == 2, k == 1));
      e = '0; e.doWriteReg = 1'b1; e.regDst = (k == 2) ? 2'b00 : 2'b01;
      push(1'b0, 1'b0, e);
      for (int n = 0; sb.size() > 0; n++) begin
        step_t s = sb.pop_front();
        iInstrReady = s.instrReady; iBusReady = s.busReady;
        @(negedge iClock);
        checks++;
        if (obs !== s.exp) begin
          errors++; $display("FAIL alu_op%0d cycle %0d: got %h expected %h", k, n, obs, s.exp);
        end
        @(posedge iClock); #1;
      end
    end
  endtask

  task automatic test_lw_wait();
    ctl_t e;
    iOperationCode = 6'b100011; iFunctionCode = 6'h00; iAluAddress = 32'h0000_0040;
    push(1'b1, 1'b0, fetchExp(1'b1));
    push(1'b0, 1'b0, ctl_t'(0));
    push(1'b0, 1'b0, execExp(2'b00, 1'b1, 1'b0));
    e = '0; e.memRead = 1'b1;
    push(1'b0, 1'b0, e);
    push(1'b0, 1'b0, e);
    push(1'b0, 1'b1, e);
    e = '0; e.doWriteReg = 1'b1; e.regSource = 2'b01;
    push(1'b0, 1'b0, e);
    for (int n = 0; sb.size() > 0; n++) begin
      step_t s = sb.pop_front();
      iInstrReady = s.instrReady; iBusReady = s.busReady;
      @(negedge iClock);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL lw_wait cycle %0d: got %h expected %h", n, obs, s.exp);
      end
      @(posedge iClock); #1;
    end
  endtask

  // Two I/O stores: in-range index 2, then index 15 (out of range for the 4-device copy).
  task automatic test_sw_io();
    ctl_t e;
    logic [31:0] addrs [2] = '{32'hFFFF_FC20, 32'hFFFF_FCF0};
    logic [15:0] sel16 [2] = '{16'h0004, 16'h8000};
    logic [3:0]  sel4  [2] = '{4'h4, 4'h0};
    for (int k = 0; k < 2; k++) begin
      iOperationCode = 6'b101011; iAluAddress = addrs[k];
      push(1'b1, 1'b0, fetchExp(1'b1));
      push(1'b0, 1'b0, ctl_t'(0));
      push(1'b0, 1'b0, execExp(2'b00, 1'b1, 1'b0));
      e = '0; e.ioWrite = 1'b1; e.ioSelect = sel16[k];
      push(1'b0, 1'b0, e);
      push(1'b0, 1'b1, e);
      push(1'b0, 1'b0, fetchExp(1'b0));
      for (int n = 0; sb.size() > 0; n++) begin
        step_t s = sb.pop_front();
        iInstrReady = s.instrReady; iBusReady = s.busReady;
        @(negedge iClock);
        checks++;
        if (obs !== s.exp) begin
          errors++; $display("FAIL sw_io%0d cycle %0d: got %h expected %h", k, n, obs, s.exp);
        end
        if (s.exp.ioWrite) begin
          checks++;
          if ({oIoWrite2, oIoSelect2, oDoMemoryWrite2} !== {1'b1, sel4[k], 1'b0}) begin
            errors++;
            $display("FAIL sw_io%0d_dev4 cycle %0d: got io=%b sel=%h mem=%b expected io=1 sel=%h mem=0",
                     k, n, oIoWrite2, oIoSelect2, oDoMemoryWrite2, sel4[k]);
          end
        end
        @(posedge iClock); #1;
      end
    end
  endtask

  task automatic test_jumps();
    ctl_t e;
    iOperationCode = 6'b000011;
    push(1'b1, 1'b0, fetchExp(1'b1));
    push(1'b0, 1'b0, ctl_t'(0));
    e = '0; e.pcWrite = 1'b1; e.pcSource = 2'b10; e.doWriteReg = 1'b1;
    e.regDst = 2'b10; e.regSource = 2'b10;
    push(1'b0, 1'b0, e);
    for (int n = 0; sb.size() > 0; n++) begin
      step_t s = sb.pop_front();
      iInstrReady = s.instrReady; iBusReady = s.busReady;
      @(negedge iClock);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL jal cycle %0d: got %h expected %h", n, obs, s.exp);
      end
      @(posedge iClock); #1;
    end
    iOperationCode = 6'b000000; iFunctionCode = 6'b001000;
    push(1'b1, 1'b0, fetchExp(1'b1));
    push(1'b0, 1'b0, ctl_t'(0));
    e = execExp(2'b10, 1'b0, 1'b0); e.pcWrite = 1'b1; e.pcSource = 2'b11;
    push(1'b0, 1'b0, e);
    for (int n = 0; sb.size() > 0; n++) begin
      step_t s = sb.pop_front();
      iInstrReady = s.instrReady; iBusReady = s.busReady;
      @(negedge iClock);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL jr cycle %0d: got %h expected %h", n, obs, s.exp);
      end
      @(posedge iClock); #1;
    end
  endtask

  task automatic test_branch();
    ctl_t e;
    for (int k = 0; k < 2; k++) begin
      iOperationCode = (k == 0) ? 6'b000100 : 6'b000101;
      push(1'b0, 1'b1, fetchExp(1'b0));
      push(1'b1, 1'b0, fetchExp(1'b1));
      push(1'b0, 1'b0, ctl_t'(0));
      e = execExp(2'b01, 1'b0, 1'b0); e.branchEval = 1'b1; e.pcSource = 2'b01; e.isBne = (k == 1);
      push(1'b0, 1'b0, e);
      for (int n = 0; sb.size() > 0; n++) begin
        step_t s = sb.pop_front();
        iInstrReady = s.instrReady; iBusReady = s.busReady;
        @(negedge iClock);
        checks++;
        if (obs !== s.exp) begin
          errors++; $display("FAIL branch%0d cycle %0d: got %h expected %h", k, n, obs, s.exp);
        end
        @(posedge iClock); #1;
      end
    end
  endtask

  task automatic test_illegal();
    ctl_t e;
    iOperationCode = 6'b111111;
    push(1'b1, 1'b0, fetchExp(1'b1));
    e = '0; e.illegal = 1'b1;
    push(1'b0, 1'b0, e);
    push(1'b0, 1'b1, fetchExp(1'b0));
    for (int n = 0; sb.size() > 0; n++) begin
      step_t s = sb.pop_front();
      iInstrReady = s.instrReady; iBusReady = s.busReady;
      @(negedge iClock);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL illegal cycle %0d: got %h expected %h", n, obs, s.exp);
      end
      @(posedge iClock); #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    ctl_t e;
    iOperationCode = 6'b101011; iAluAddress = 32'hFFFF_FC20;
    push(1'b1, 1'b0, fetchExp(1'b1));
    push(1'b0, 1'b0, ctl_t'(0));
    push(1'b0, 1'b0, execExp(2'b00, 1'b1, 1'b0));
    e = '0; e.ioWrite = 1'b1; e.ioSelect = 16'h0004;
    push(1'b0, 1'b0, e);
    for (int n = 0; sb.size() > 0; n++) begin
      step_t s = sb.pop_front();
      iInstrReady = s.instrReady; iBusReady = s.busReady;
      @(negedge iClock);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL reset_mid cycle %0d: got %h expected %h", n, obs, s.exp);
      end
      if (sb.size() > 0) begin @(posedge iClock); #1; end
    end
    #2 iReset = 1'b1;
    #1;
    checks++;
    if (obs !== ctl_t'(0)) begin
      errors++; $display("FAIL reset_mid_async: got %h expected %h", obs, ctl_t'(0));
    end
    @(posedge iClock); #1;
    iReset = 1'b0;
    @(negedge iClock);
    checks++;
    if (obs !== fetchExp(1'b0)) begin
      errors++; $display("FAIL reset_mid_refetch: got %h expected %h", obs, fetchExp(1'b0));
    end
    @(posedge iClock); #1;
  endtask

`ifdef CPU_CONTROLLER_BUS_TIMEOUT_EN
  task automatic test_timeout();
    ctl_t e;
    iOperationCode = 6'b101011; iAluAddress = 32'h0000_0100;
    push(1'b1, 1'b0, fetchExp(1'b1));
    push(1'b0, 1'b0, ctl_t'(0));
    push(1'b0, 1'b0, execExp(2'b00, 1'b1, 1'b0));
    e = '0; e.memWrite = 1'b1;
    repeat (7) push(1'b0, 1'b0, e);
    e.busError = 1'b1;
    push(1'b0, 1'b0, e);
    push(1'b0, 1'b0, fetchExp(1'b0));
    for (int n = 0; sb.size() > 0; n++) begin
      step_t s = sb.pop_front();
      iInstrReady = s.instrReady; iBusReady = s.busReady;
      @(negedge iClock);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL timeout cycle %0d: got %h expected %h", n, obs, s.exp);
      end
      @(posedge iClock); #1;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_ops();
    test_lw_wait();
    test_sw_io();
    test_jumps();
    test_branch();
    test_illegal();
    test_reset_mid_mem();
`ifdef CPU_CONTROLLER_BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
